// File: rtl/nonce_search_controller.sv
// nonce_search_controller: sweeps a nonce range through a SHA block until a digest <= target, range end, or timeout.
// Optional feature: define NONCE_SEARCH_ABORT_EN to add an abort input that ends a running search with no flags.
module nonce_search_controller #(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic         clk,
  input  logic         n_rst,
`ifdef NONCE_SEARCH_ABORT_EN
  input  logic         abort,
`endif
  input  logic         start,
  input  logic [607:0] header_in,
  input  logic [255:0] target,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  output logic         sha_begin,
  output logic [639:0] sha_msg,
  input  logic         sha_complete,
  input  logic [255:0] sha_digest,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         timeout,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  attempts
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  state_t r_state, w_next;
  logic [607:0] r_hdr;
  logic [255:0] r_target, r_digest, r_found_hash;
  logic [31:0]  r_nonce, r_end, r_wd, r_attempts, r_found_nonce;
  logic         r_found, r_exhausted, r_timeout;
  logic         w_abort, w_hit, w_last, w_wd_exp;
`ifdef NONCE_SEARCH_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif
  assign w_hit    = r_digest <= r_target;
  assign w_last   = r_nonce == r_end;
  assign w_wd_exp = r_wd == WD_LAST;
  assign sha_msg     = {r_hdr, r_nonce[7:0], r_nonce[15:8], r_nonce[23:16], r_nonce[31:24]};
  assign found       = r_found;
  assign exhausted   = r_exhausted;
  assign timeout     = r_timeout;
  assign found_nonce = r_found_nonce;
  assign found_hash  = r_found_hash;
  assign attempts    = r_attempts;
  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // next-state, begin pulse and busy decode
  always_comb begin
    w_next    = r_state;
    sha_begin = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: w_next = start ? S_ISSUE : r_state;
      S_ISSUE: begin
        sha_begin = 1'b1;
        busy      = 1'b1;
        w_next    = w_abort ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        busy   = 1'b1;
        w_next = w_abort ? S_DONE : sha_complete ? S_CHECK : w_wd_exp ? S_DONE : S_WAIT;
      end
      S_CHECK: begin
        busy   = 1'b1;
        w_next = (w_abort || w_hit || w_last) ? S_DONE : S_ISSUE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  // search datapath: capture, watchdog, digest compare and result flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hdr         <= '0;
      r_target      <= '0;
      r_digest      <= '0;
      r_found_hash  <= '0;
      r_nonce       <= '0;
      r_end         <= '0;
      r_wd          <= '0;
      r_attempts    <= '0;
      r_found_nonce <= '0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_hdr       <= header_in;
          r_target    <= target;
          r_nonce     <= nonce_start;
          r_end       <= nonce_end;
          r_attempts  <= '0;
          r_found     <= 1'b0;
          r_exhausted <= 1'b0;
          r_timeout   <= 1'b0;
        end
        S_ISSUE: r_wd <= '0;
        S_WAIT: if (!w_abort) begin
          if (sha_complete) begin
            r_digest   <= sha_digest;
            r_attempts <= r_attempts + {31'b0, r_attempts != '1};
          end else begin
            r_wd <= r_wd + 32'd1;
            if (w_wd_exp) r_timeout <= 1'b1;
          end
        end
        S_CHECK: if (!w_abort) begin
          if (w_hit) begin
            r_found       <= 1'b1;
            r_found_nonce <= r_nonce;
            r_found_hash  <= r_digest;
          end else if (w_last) r_exhausted <= 1'b1;
          else r_nonce <= r_nonce + 32'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/nonce_search_controller.md
Name: nonce_search_controller

Overview:
- Initiator side of the 640-bit SHA compute interface (begin pulse, message bus, completion strobe, 256-bit digest).
- Builds the 640-bit block header from a 608-bit header prefix and a 32-bit nonce, issues it, and compares each digest against a target.
- Sweeps an inclusive nonce range until a hit, range exhaustion, or compute timeout.
- Sits between the host/config registers and the SHA compute block.

Parameters:
- TIMEOUT_CYCLES, 200: maximum cycles in WAIT for sha_complete before a timeout is declared.

Ports:
- clk  input  1  clock
- n_rst  input  1  reset, asynchronous, active-low
- start  input  1  begin a search; sampled only in IDLE or DONE
- header_in  input  608  header prefix (bits 639:32 of the message)
- target  input  256  hit threshold, unsigned
- nonce_start  input  32  first nonce
- nonce_end  input  32  last nonce, inclusive
- sha_begin  output  1  one-cycle start pulse to the SHA block
- sha_msg  output  640  message to the SHA block
- sha_complete  input  1  one-cycle completion strobe from the SHA block
- sha_digest  input  256  digest; valid in the sha_complete cycle
- busy  output  1  search in progress
- found  output  1  hit flag
- exhausted  output  1  range done with no hit
- timeout  output  1  SHA block failed to complete in time
- found_nonce  output  32  nonce that produced the hit
- found_hash  output  256  digest of the hit
- attempts  output  32  count of digests checked in the current search

Behaviour:
- Reset: state IDLE. All outputs 0, including sha_msg, found_nonce, found_hash and attempts. Internal registers cleared. Reset mid-search abandons the search with no output pulse.
- sha_msg = {hdr_reg, byteswap(nonce_reg)}, where byteswap reverses the 4 bytes (0x11223344 -> 0x44332211).
  - sha_msg is registered and driven from state, never directly from inputs.
  - It is held stable from the sha_begin cycle through the sha_complete cycle, because the SHA block re-samples its message every cycle.
- IDLE / DONE + start=1:
  - Capture header_in, target, nonce_start (into nonce_reg) and nonce_end.
  - Clear found, exhausted, timeout and attempts. Next state ISSUE.
  - start=0: hold the current state and all result outputs.
- ISSUE: sha_begin=1 for exactly this cycle. Clear the watchdog. Next state WAIT.
- WAIT:
  - sha_complete=1: register sha_digest, attempts+1, next state CHECK.
  - Otherwise watchdog+1. When the watchdog reaches TIMEOUT_CYCLES: timeout=1, next state DONE.
  - sha_complete outside WAIT is ignored.
- CHECK:
  - digest_reg <= target (256-bit unsigned): found=1, found_nonce=nonce_reg, found_hash=digest_reg, next state DONE.
  - Else nonce_reg == end_reg: exhausted=1, next state DONE.
  - Else nonce_reg = nonce_reg+1 mod 2^32, next state ISSUE.
- busy=1 in ISSUE, WAIT and CHECK; 0 in IDLE and DONE. start while busy is ignored.
- Flags found, exhausted and timeout are mutually exclusive and held in DONE until the next accepted start.
- Per-nonce period = SHA latency + 3 cycles (ISSUE, WAIT capture, CHECK).
- Range wraps: nonce_start > nonce_end sweeps through 0xFFFFFFFF -> 0x00000000. nonce_start == nonce_end tests exactly one nonce. 0 to 0xFFFFFFFF tests all 2^32 nonces.
- A hit on the final nonce reports found, not exhausted.
- attempts saturates at 0xFFFFFFFF.

Optional Feature:
- Macro NONCE_SEARCH_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in ISSUE, WAIT or CHECK forces next state DONE with all three flags 0. Any in-flight sha_complete is dropped. attempts holds its value. abort in IDLE or DONE has no effect.
- Undefined: no abort port; a search ends only via found, exhausted, timeout or reset.

Test Plan:
- Target all-ones, nonce_start=0x00000010, end=0x000000FF, bench SHA model with 130-cycle latency -> found=1 after 1 attempt, found_nonce=0x00000010, sha_msg[31:0]=0x10000000, busy low 1 cycle after the hit.
- Target 0, range 0x00000005..0x00000009, model digest = nonce+1 -> exhausted=1, attempts=5, exactly 5 sha_begin pulses, sha_msg stable during each WAIT.
- Range 0xFFFFFFFE..0x00000001, target 0 -> sha_begin nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001 in order; exhausted=1, attempts=4.
- Model never asserts sha_complete -> timeout=1 exactly TIMEOUT_CYCLES cycles after entering WAIT; found=exhausted=0; attempts=0.
- Model digest == target on the 3rd nonce (boundary equality) -> found=1, found_hash=target, attempts=3; a start pulse during the search is ignored. Then start again in DONE -> flags clear and a fresh search runs.
- n_rst low during WAIT -> all outputs 0 immediately, state IDLE. With NONCE_SEARCH_ABORT_EN, abort in WAIT -> DONE, no flags set, late sha_complete ignored.
